// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register plus data-memory req/ack control.
// Stalls the front end while an access is outstanding and resolves CBZ at retire.
module mem_access_stage #(
  parameter int N       = 64,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         flush_M,
  input  logic         Branch_E,
  input  logic         MemRead_E,
  input  logic         MemWrite_E,
  input  logic         RegWrite_E,
  input  logic         zero_E,
  input  logic [4:0]   writeReg_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic [N-1:0] dm_rdata,
  input  logic         dm_ack,
  output logic         stall_M,
  output logic         retire_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] readData_M,
  output logic         RegWrite_M,
  output logic [4:0]   writeReg_M,
  output logic         memError_M
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  typedef struct packed {
    logic         valid;
    logic         branch;
    logic         mem_read;
    logic         mem_write;
    logic         reg_write;
    logic         zero;
    logic [4:0]   wreg;
    logic [N-1:0] pc_branch;
    logic [N-1:0] alu;
    logic [N-1:0] wdata;
  } m_reg_t;

  m_reg_t     m_q;
  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       ld_memop;
  logic       memop_M;
  logic       timeout_hit;

  assign ld_memop    = valid_E & ~flush_M & (MemRead_E | MemWrite_E);
  assign memop_M     = m_q.mem_read | m_q.mem_write;
  assign timeout_hit = (state == WAIT) & ~dm_ack & (cnt == 8'(TIMEOUT - 1));

  // EX/MEM register: every field frozen while stalled
  always_ff @(posedge clk) begin
    if (reset)
      m_q <= '0;
    else if (!stall_M)
      m_q <= '{valid:     valid_E & ~flush_M,
               branch:    Branch_E,
               mem_read:  MemRead_E,
               mem_write: MemWrite_E,
               reg_write: RegWrite_E,
               zero:      zero_E,
               wreg:      writeReg_E,
               pc_branch: PCBranch_E,
               alu:       aluResult_E,
               wdata:     writeData_E};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // IDLE never stalls, so every IDLE edge is a load edge
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ld_memop) state_nxt = WAIT;
      WAIT:    if (dm_ack)           state_nxt = ld_memop ? WAIT : IDLE;
               else if (timeout_hit) state_nxt = ERR;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // Wait counter restarts whenever a fresh access begins, including ack-chained ones
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      memError_M <= 1'b0;
    end else begin
      if (state_nxt == WAIT && (state != WAIT || dm_ack))
        cnt <= '0;
      else if (state == WAIT && !dm_ack)
        cnt <= cnt + 8'd1;
      if (timeout_hit)
        memError_M <= 1'b1;
    end
  end

  always_comb begin
    dm_req   = (state == WAIT);
    dm_we    = (state == WAIT) & m_q.mem_write;
    stall_M  = ((state == WAIT) & ~dm_ack) | (state == ERR);
    retire_M = m_q.valid & (((state == IDLE) & ~memop_M) | ((state == WAIT) & dm_ack));
    PCSrc_M  = retire_M & m_q.branch & m_q.zero;
  end

  assign dm_addr     = m_q.alu;
  assign dm_wdata    = m_q.wdata;
  assign PCBranch_M  = m_q.pc_branch;
  assign aluResult_M = m_q.alu;
  assign readData_M  = dm_rdata;
  assign RegWrite_M  = m_q.valid & m_q.reg_write;
  assign writeReg_M  = m_q.wreg;

endmodule
